muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS-lite core. It executes MULT, MULTU and DIVU iteratively over WIDTH cycles, serves MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while an operation is in flight. It sits beside the ALU in EX and consumes the same `alu_control` code the ALU control decoder produces.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be a power of two.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  EX holds a valid instruction this cycle.
- `alu_control`  in  `ALU_CONTROL_LENGTH`  decoded operation code.
- `src_a`  in  WIDTH  rs value (multiplicand / dividend / MTxx data).
- `src_b`  in  WIDTH  rt value (multiplier / divisor).
- `stall`  out  1  the offered HI/LO operation is not accepted this cycle.
- `busy`  out  1  a MULT/MULTU/DIVU is in progress.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `mf_data`  out  WIDTH  MFHI→`hi`, MFLO→`lo`, otherwise 0.

## Operation
- HI/LO ops: `ALU_CONTROL_MULT`, `ALU_CONTROL_MULTU`, `ALU_CONTROL_DIVU`, `ALU_CONTROL_MTHI`, `ALU_CONTROL_MTLO`, `ALU_CONTROL_MFHI`, `ALU_CONTROL_MFLO`. All other codes are ignored and never stall.
- An op is accepted when `op_valid`, the code is a HI/LO op, and `stall`=0.
- `stall` = `op_valid` & HI/LO op & (state≠IDLE). It is combinational. The requester holds its inputs until `stall` drops.
- FSM states:
  - IDLE: accepting MULT/MULTU/DIVU latches the operands, clears the accumulator, sets counter=0 and moves to RUN. MTHI/MTLO write `src_a` into HI/LO at the edge and stay in IDLE. MFHI/MFLO have no state effect.
  - RUN: one iteration per cycle. When counter=WIDTH-1, move to FINISH; otherwise increment the counter.
  - FINISH: write HI/LO, then go to IDLE.
- MULTU: unsigned shift-add producing a 2·WIDTH-bit product; HI = upper half, LO = lower half.
- MULT: the datapath multiplies |src_a|·|src_b|. If the sign bits differ, FINISH applies two's-complement negation to the 2·WIDTH-bit result. The most-negative operand's magnitude is handled as an unsigned WIDTH-bit value.
- DIVU: restoring division. LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = src_a. The full WIDTH cycles still run.
- HI/LO are untouched until FINISH. An in-flight op never corrupts them mid-run.
- `rst` in any state: state→IDLE, counter=0, HI=LO=0, accumulator=0. An in-flight op is discarded with no HI/LO write.

## Timing
- Reset values: `stall`=0, `busy`=0, `hi`=0, `lo`=0, `mf_data`=0.
- Accept of MULT/MULTU/DIVU on edge N:
  - `busy`=1 for cycles N+1 … N+WIDTH+1 (RUN ×WIDTH, FINISH ×1).
  - HI/LO are updated on edge N+WIDTH+1 and visible from cycle N+WIDTH+2. Latency is WIDTH+2 cycles (34 at WIDTH=32).
- A HI/LO op stalled during FINISH is accepted in the next cycle (IDLE) and observes the new HI/LO.
- MTHI/MTLO: 1-cycle write. A following MFHI/MFLO sees the new value in the next cycle. No same-cycle bypass.
- `mf_data` is combinational from the `hi`/`lo` registers and `alu_control`. It is valid only when not stalled.
- Only one op is offered per cycle, so no simultaneous-request arbitration exists.

## Structure
- `head.v` gains `MD_IDLE`, `MD_RUN`, `MD_FINISH` (2-bit) and `MD_CNT_LENGTH` = log2(WIDTH).
- The existing `ALU_CONTROL_*` codes are reused unchanged.
- One sub-module, `muldiv_datapath`: the 2·WIDTH accumulator, shift/add/subtract-restore step, sign fix-up and div-by-zero result. It takes `step`, `load`, `finish` and mode inputs from the FSM in `muldiv_sequencer`.
- `muldiv_sequencer` keeps the FSM, counter, HI/LO registers and stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000005 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0xFFFFFFFF → HI=0x00000000, LO=0x80000000.
- DIVU 100 / 7 → LO=14, HI=2. DIVU 0x00001234 / 0 → LO=0xFFFFFFFF, HI=0x00001234.
- MFLO offered the cycle after a MULTU 6×7 accept:
  - `stall`=1 through FINISH.
  - Next cycle `stall`=0 and `mf_data`=42.
  - A non-HI/LO op offered mid-run never stalls.
- MTHI 0xA5A5A5A5, then MFHI next cycle → `mf_data`=0xA5A5A5A5, `stall`=0 both cycles.
- `rst` asserted at RUN iteration 10 of DIVU → next cycle `busy`=0, `hi`=`lo`=0. A subsequent MULTU 6×7 → LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - ALU control codes (the same codes the ALU control decoder produces)
//   - FSM state encoding and datapath mode
//   - helper functions used to classify an offered ALU control code
package muldiv_sequencer_pkg;

    localparam int ALU_CONTROL_LENGTH = 5;
    typedef logic [ALU_CONTROL_LENGTH-1:0] alu_control_t;

    localparam alu_control_t ALU_CONTROL_ADD   = 5'd2;
    localparam alu_control_t ALU_CONTROL_SUB   = 5'd6;
    localparam alu_control_t ALU_CONTROL_AND   = 5'd0;
    localparam alu_control_t ALU_CONTROL_OR    = 5'd1;
    localparam alu_control_t ALU_CONTROL_MULT  = 5'd16;
    localparam alu_control_t ALU_CONTROL_MULTU = 5'd17;
    localparam alu_control_t ALU_CONTROL_DIVU  = 5'd18;
    localparam alu_control_t ALU_CONTROL_MTHI  = 5'd19;
    localparam alu_control_t ALU_CONTROL_MTLO  = 5'd20;
    localparam alu_control_t ALU_CONTROL_MFHI  = 5'd21;
    localparam alu_control_t ALU_CONTROL_MFLO  = 5'd22;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_RUN    = 2'd1,
        MD_FINISH = 2'd2
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MODE_MULTU = 2'd0,
        MD_MODE_MULT  = 2'd1,
        MD_MODE_DIVU  = 2'd2
    } md_mode_t;

    // Iteration counter width for a given operand width.
    function automatic int md_cnt_length(input int width);
        return $clog2(width);
    endfunction

    // Any code that touches HI/LO (and therefore may stall).
    function automatic logic is_hilo_op(input alu_control_t code);
        case (code)
            ALU_CONTROL_MULT, ALU_CONTROL_MULTU, ALU_CONTROL_DIVU,
            ALU_CONTROL_MTHI, ALU_CONTROL_MTLO,
            ALU_CONTROL_MFHI, ALU_CONTROL_MFLO: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Codes that start a multi-cycle iteration.
    function automatic logic is_long_op(input alu_control_t code);
        return (code == ALU_CONTROL_MULT) || (code == ALU_CONTROL_MULTU) ||
               (code == ALU_CONTROL_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
//   master (EX pipeline): drives op_valid, alu_control, src_a, src_b
//   slave  (muldiv unit): drives stall, busy, hi, lo, mf_data
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              op_valid;
    alu_control_t      alu_control;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic              stall;
    logic              busy;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  mf_data;

    modport master (
        output op_valid, alu_control, src_a, src_b,
        input  stall, busy, hi, lo, mf_data
    );

    modport slave (
        input  op_valid, alu_control, src_a, src_b,
        output stall, busy, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath.
//   load   : capture operand magnitudes and mode, clear the accumulator
//   step   : one shift-add (multiply) or shift-subtract-restore (divide) iteration
//   finish : result has been consumed; clear the accumulator
//   result : {HI, LO} image of the accumulator with MULT sign fix-up applied
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  md_mode_t           mode,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   op_a;     // multiplicand, or dividend shifted out MSB first
    logic [WIDTH-1:0]   op_b;     // multiplier shifted out LSB first, or divisor
    md_mode_t           mode_q;
    logic               neg_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ok;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        mag_a = src_a;
        mag_b = src_b;
        if (mode == MD_MODE_MULT) begin
            // 0x8000... negates to itself, which is its correct unsigned magnitude.
            if (src_a[WIDTH-1]) mag_a = WIDTH'(0) - src_a;
            if (src_b[WIDTH-1]) mag_b = WIDTH'(0) - src_b;
        end
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, op_b};
        // With a zero divisor every trial subtract succeeds: the quotient fills
        // with ones and the remainder ends up equal to the dividend.
        rem_ok    = (rem_shift >= {1'b0, op_b});
        result    = neg_q ? ((2*WIDTH)'(0) - acc) : acc;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            mode_q <= MD_MODE_MULTU;
            neg_q  <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            op_a   <= mag_a;
            op_b   <= mag_b;
            mode_q <= mode;
            neg_q  <= (mode == MD_MODE_MULT) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end else if (step) begin
            if (mode_q == MD_MODE_DIVU) begin
                // Upper half holds the partial remainder, quotient bits enter at the bottom.
                acc  <= {(rem_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                         acc[WIDTH-2:0], rem_ok};
                op_a <= op_a << 1;
            end else begin
                // Partial product grows in the upper half and shifts down into LO.
                acc  <= {add_sum, acc[WIDTH-1:1]};
                op_b <= op_b >> 1;
            end
        end else if (finish) begin
            acc   <= '0;
            neg_q <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer for the MIPS-lite EX stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of muldiv_sequencer_if
//              op_valid/alu_control/src_a/src_b in; stall/busy/hi/lo/mf_data out
// Owns the IDLE/RUN/FINISH FSM, the iteration counter, HI/LO and the stall
// decision; the arithmetic lives in muldiv_datapath.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);

    localparam int CNT_W = md_cnt_length(WIDTH);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               hilo_op;
    logic               accept;
    logic               start;
    md_mode_t           mode;
    logic [2*WIDTH-1:0] dp_result;

    assign hilo_op   = is_hilo_op(bus.alu_control);
    assign bus.stall = bus.op_valid && hilo_op && (state != MD_IDLE);
    assign accept    = bus.op_valid && hilo_op && !bus.stall;
    assign start     = accept && is_long_op(bus.alu_control);

    always_comb begin
        mode = MD_MODE_MULTU;
        case (bus.alu_control)
            ALU_CONTROL_MULT: mode = MD_MODE_MULT;
            ALU_CONTROL_DIVU: mode = MD_MODE_DIVU;
            default:          mode = MD_MODE_MULTU;
        endcase
    end

    always_comb begin
        bus.mf_data = '0;
        if (bus.alu_control == ALU_CONTROL_MFHI)      bus.mf_data = hi_q;
        else if (bus.alu_control == ALU_CONTROL_MFLO) bus.mf_data = lo_q;
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .step   (state == MD_RUN),
        .finish (state == MD_FINISH),
        .mode   (mode),
        .src_a  (bus.src_a),
        .src_b  (bus.src_b),
        .result (dp_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state  <= MD_RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else if (accept && bus.alu_control == ALU_CONTROL_MTHI) begin
                        hi_q <= bus.src_a;
                    end else if (accept && bus.alu_control == ALU_CONTROL_MTLO) begin
                        lo_q <= bus.src_a;
                    end
                end
                MD_RUN: begin
                    if (cnt == CNT_W'(WIDTH - 1)) state <= MD_FINISH;
                    else                          cnt   <= cnt + CNT_W'(1);
                end
                MD_FINISH: begin
                    hi_q   <= dp_result[2*WIDTH-1:WIDTH];
                    lo_q   <= dp_result[WIDTH-1:0];
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    state  <= MD_IDLE;
                end
                default: begin
                    state  <= MD_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
